// File: rtl/vga_decodifica_embarcacao.sv
// rtl/vga_decodifica_embarcacao.sv - decodes a ship position vector into a 10x10 grid and answers VGA pixel hits
module vga_decodifica_embarcacao #(
    parameter int GRID_X0   = 40,
    parameter int GRID_Y0   = 40,
    parameter int CELL_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        carregar,
    input  logic [63:0] posicoesEmbarcacao,
    input  logic [9:0]  pixelX,
    input  logic [9:0]  pixelY,
    output logic        ocupado,
    output logic        pronto,
    output logic        erro,
    output logic        celulaOcupada,
    output logic [99:0] celulas
);

    localparam int BOARD_PX = 10 << CELL_LOG2;

    typedef enum logic [1:0] {OCIOSO, DECODIFICA, CONCLUI} estado_t;

    estado_t     estado;
    estado_t     proximo;
    logic [42:0] vetor;
    logic [2:0]  k;
    logic [20:0] bits_unused;

    logic [3:0]  par_x;
    logic [3:0]  par_y;
    logic        par_valido;
    logic [6:0]  idx_par;
    logic        ultimo;
    logic        tipo_invalido;

    assign bits_unused   = posicoesEmbarcacao[63:43];
    assign tipo_invalido = posicoesEmbarcacao[2:0] > 3'd4;

    // Pair k lives at bits 8k+3 (X) and 8k+7 (Y).
    assign par_x      = vetor[{k, 3'b011} +: 4];
    assign par_y      = vetor[{k, 3'b111} +: 4];
    assign par_valido = (par_x <= 4'd9) && (par_y <= 4'd9);
    assign idx_par    = 7'(par_y) * 7'd10 + 7'(par_x);
    assign ultimo     = (k == vetor[2:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:     if (carregar) proximo = tipo_invalido ? CONCLUI : DECODIFICA;
            DECODIFICA: if (ultimo) proximo = CONCLUI;
            CONCLUI:    proximo = OCIOSO;
            default:    proximo = OCIOSO;
        endcase
    end

    always_comb begin
        ocupado = (estado == DECODIFICA);
        pronto  = (estado == CONCLUI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vetor   <= '0;
            k       <= '0;
            celulas <= '0;
            erro    <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (carregar) begin
                        vetor   <= posicoesEmbarcacao[42:0];
                        k       <= '0;
                        celulas <= '0;
                        erro    <= tipo_invalido;
                    end
                end
                DECODIFICA: begin
                    k <= k + 3'd1;
                    if (par_valido) begin
                        celulas[idx_par] <= 1'b1;
                    end else begin
                        erro <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic        dentro;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [6:0]  idx_pix;
    logic [99:0] desl;

    assign dentro  = (pixelX >= 10'(GRID_X0)) && (pixelX < 10'(GRID_X0 + BOARD_PX)) &&
                     (pixelY >= 10'(GRID_Y0)) && (pixelY < 10'(GRID_Y0 + BOARD_PX));
    assign dx      = pixelX - 10'(GRID_X0);
    assign dy      = pixelY - 10'(GRID_Y0);
    assign idx_pix = 7'(4'(dy >> CELL_LOG2)) * 7'd10 + 7'(4'(dx >> CELL_LOG2));
    // Shift rather than index so out-of-board pixels never address past bit 99.
    assign desl    = celulas >> idx_pix;

    always_ff @(posedge clk) begin
        if (reset) begin
            celulaOcupada <= 1'b0;
        end else begin
            celulaOcupada <= dentro && !ocupado && desl[0];
        end
    end

endmodule

// File: tb/tb_vga_decodifica_embarcacao.sv
// tb/tb_vga_decodifica_embarcacao.sv - directed and randomized checks of the ship vector decoder
module tb_vga_decodifica_embarcacao;

    logic        clk = 1'b0;
    logic        reset;
    logic        carregar;
    logic [63:0] posicoesEmbarcacao;
    logic [9:0]  pixelX;
    logic [9:0]  pixelY;
    logic        ocupado;
    logic        pronto;
    logic        erro;
    logic        celulaOcupada;
    logic [99:0] celulas;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [99:0] exp_grid;
    bit          exp_err;

    vga_decodifica_embarcacao #(.GRID_X0(40), .GRID_Y0(40), .CELL_LOG2(5)) dut (
        .clk(clk), .reset(reset), .carregar(carregar),
        .posicoesEmbarcacao(posicoesEmbarcacao), .pixelX(pixelX), .pixelY(pixelY),
        .ocupado(ocupado), .pronto(pronto), .erro(erro),
        .celulaOcupada(celulaOcupada), .celulas(celulas)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [99:0] obs, input logic [99:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] mkv(input int t, input int x0, input int y0, input int x1,
                                        input int y1, input int x2, input int y2, input int x3,
                                        input int y3, input int x4, input int y4);
        return 64'(t) | (64'(x0) << 3) | (64'(y0) << 7) | (64'(x1) << 11) | (64'(y1) << 15) |
               (64'(x2) << 19) | (64'(y2) << 23) | (64'(x3) << 27) | (64'(y3) << 31) |
               (64'(x4) << 35) | (64'(y4) << 39);
    endfunction

    // Reference: ship of length T+1, each pair either marks its cell or flags an error.
    function automatic void model(input logic [63:0] v, output logic [99:0] grid,
                                  output bit err, output int ndec);
        int t = int'(v[2:0]);
        int x;
        int y;
        grid = '0;
        err  = 0;
        ndec = 0;
        if (t > 4) begin
            err = 1;
            return;
        end
        ndec = t + 1;
        for (int p = 0; p < ndec; p++) begin
            x = int'((v >> (3 + 8 * p)) & 64'hF);
            y = int'((v >> (7 + 8 * p)) & 64'hF);
            if (x < 10 && y < 10) grid[y * 10 + x] = 1'b1;
            else err = 1;
        end
    endfunction

    // Called at a negedge with the FSM idle; returns at the negedge where the next load may be driven.
    task automatic load(input logic [63:0] v, input bit hold);
        int ndec;
        model(v, exp_grid, exp_err, ndec);
        carregar = 1'b1;
        posicoesEmbarcacao = v;
        @(negedge clk);
        if (!hold) carregar = 1'b0;
        for (int i = 0; i < ndec; i++) begin
            chk("ocupado_dec", 100'(ocupado), 100'(1));
            chk("pronto_dec", 100'(pronto), 100'(0));
            if (i == 0) begin
                chk("celulas_cleared", celulas, '0);
                chk("erro_cleared", 100'(erro), 100'(0));
            end
            if (hold) posicoesEmbarcacao = {$urandom, $urandom};
            @(negedge clk);
        end
        chk("ocupado_end", 100'(ocupado), 100'(0));
        chk("pronto_pulse", 100'(pronto), 100'(1));
        if (ndec == 0) chk("celulas_badtype", celulas, '0);
        @(negedge clk);
        chk("pronto_low", 100'(pronto), 100'(0));
        chk("celulas", celulas, exp_grid);
        chk("erro", 100'(erro), 100'(exp_err));
    endtask

    task automatic pix(input int x, input int y);
        logic expv;
        carregar = 1'b0;
        pixelX = 10'(x);
        pixelY = 10'(y);
        @(negedge clk);
        if (x >= 40 && x < 360 && y >= 40 && y < 360)
            expv = exp_grid[((y - 40) / 32) * 10 + (x - 40) / 32];
        else
            expv = 1'b0;
        chk("celulaOcupada", 100'(celulaOcupada), 100'(expv));
    endtask

    initial begin
        logic [63:0] v;
        int          c;
        reset = 1'b1;
        carregar = 1'b1;
        posicoesEmbarcacao = 64'h2A8;
        pixelX = '0;
        pixelY = '0;
        exp_grid = '0;
        repeat (2) @(negedge clk);
        chk("rst_ocupado", 100'(ocupado), 100'(0));
        chk("rst_pronto", 100'(pronto), 100'(0));
        chk("rst_erro", 100'(erro), 100'(0));
        chk("rst_celulas", celulas, '0);
        chk("rst_flag", 100'(celulaOcupada), 100'(0));
        reset = 1'b0;
        carregar = 1'b0;
        @(negedge clk);

        load(64'h2A8, 0);
        chk("t1_bit55", celulas, 100'(1) << 55);
        pix(203, 203);
        pix(235, 203);

        load(64'h98908A, 0);
        pix(39, 75);
        pix(50, 75);
        pix(150, 75);

        load(mkv(1, 12, 2, 3, 3, 0, 0, 0, 0, 0, 0), 0);
        load(mkv(6, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5), 0);

        load(mkv(4, 0, 0, 1, 2, 9, 9, 4, 7, 8, 3), 1);
        load(mkv(0, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        pix(40 + 7 * 32 + 5, 40 + 8 * 32 + 31);
        pix(359, 359);

        // Reset lands in the second decode cycle of a length-4 ship.
        carregar = 1'b1;
        posicoesEmbarcacao = mkv(3, 2, 2, 3, 3, 4, 4, 5, 5, 0, 0);
        @(negedge clk);
        carregar = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_grid = '0;
        chk("r6_celulas", celulas, '0);
        chk("r6_ocupado", 100'(ocupado), 100'(0));
        chk("r6_pronto", 100'(pronto), 100'(0));
        chk("r6_erro", 100'(erro), 100'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("r6_no_pronto", 100'(pronto), 100'(0));
        end
        load(64'h2A8, 0);
        pix(203, 203);

        for (int it = 0; it < 10; it++) begin
            v = {$urandom, $urandom};
            v[2:0] = 3'($urandom_range(0, 5));
            load(v, 0);
            for (int q = 0; q < 3; q++) pix($urandom_range(0, 420), $urandom_range(0, 420));
            c = $urandom_range(0, 99);
            pix(40 + (c % 10) * 32 + 16, 40 + (c / 10) * 32 + 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
